// File: rtl/beep_sched_pkg.sv
// Shared definitions for the buzzer scheduler: FSM state encoding, default widths
// and the minimum tone half-period.
package beep_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_TONE_W   = 15;
  localparam int DEF_DUR_W    = 16;
  localparam int DEF_REP_W    = 4;
  localparam int DEF_TICK_DIV = 50000;

  localparam int MIN_TONE = 2;

endpackage

// File: rtl/beep_sched_tone_gen.sv
// beep_tone_gen: square wave of half-period half_i while en_i is high; restart_i marks
// the first cycle of a burst so the wave always starts with a full high half.
module beep_tone_gen
  import beep_sched_pkg::*;
#(
  parameter int TONE_W = DEF_TONE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic [TONE_W-1:0] half_i,
  output logic              beep_o
);

  logic [TONE_W:0] cnt_q;
  logic [TONE_W:0] cnt_cur;
  logic [TONE_W:0] period_m1;

  assign period_m1 = {half_i, 1'b0} - (TONE_W+1)'(1);
  assign cnt_cur   = restart_i ? '0 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beep_o <= 1'b0;
    end else begin
      beep_o <= en_i && (cnt_cur < {1'b0, half_i});
      if (!en_i)
        cnt_q <= '0;
      else if (cnt_cur == period_m1)
        cnt_q <= '0;
      else
        cnt_q <= cnt_cur + (TONE_W+1)'(1);
    end
  end

endmodule

// File: rtl/beep_sched.sv
// beep_sched: fixed-priority buzzer scheduler playing (ON, OFF) x reps patterns.
// Optional preemption by higher-priority requesters: define BEEP_SCHED_PREEMPT_EN.
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready offered to lowest valid index
//   ON    | tone playing for on x TICK_DIV cycles
//   OFF   | silent for off x TICK_DIV cycles
//   DONE  | one-cycle completion pulse, then IDLE
module beep_sched
  import beep_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int TONE_W   = DEF_TONE_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int REP_W    = DEF_REP_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*TONE_W-1:0]  req_tone,
  input  logic [NUM_REQ*DUR_W-1:0]   req_on,
  input  logic [NUM_REQ*DUR_W-1:0]   req_off,
  input  logic [NUM_REQ*REP_W-1:0]   req_reps,
  output logic                       beep,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PRE_W = $clog2(TICK_DIV);

  state_e            state_q;
  logic [TONE_W-1:0] tone_q;
  logic [DUR_W-1:0]  on_q, off_q, dur_q;
  logic [REP_W-1:0]  reps_q, rep_q;
  logic [PRE_W-1:0]  pre_q;
  logic [ID_W-1:0]   active_id_q;
  logic              done_q;
  logic              tone_rst_q;

  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    gidx;
  logic               hs;
  logic [TONE_W-1:0]  g_tone_raw, g_tone;
  logic [DUR_W-1:0]   g_on, g_off;
  logic [REP_W-1:0]   g_reps_raw, g_reps;
  logic [DUR_W-1:0]   cur_dur;
  logic               pre_end, dur_end, last_rep;

  always_comb begin
    elig = '0;
    if (state_q == IDLE)
      elig = req_valid;
`ifdef BEEP_SCHED_PREEMPT_EN
    else if (state_q == ON || state_q == OFF) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (i < int'(active_id_q)) elig[i] = req_valid[i];
    end
`endif
    gidx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (elig[i]) gidx = ID_W'(i);
    req_ready = '0;
    if (|elig) req_ready[gidx] = 1'b1;
  end

  assign hs = |(req_valid & req_ready);

  assign g_tone_raw = req_tone[int'(gidx)*TONE_W +: TONE_W];
  assign g_on       = req_on[int'(gidx)*DUR_W +: DUR_W];
  assign g_off      = req_off[int'(gidx)*DUR_W +: DUR_W];
  assign g_reps_raw = req_reps[int'(gidx)*REP_W +: REP_W];
  assign g_tone     = (g_tone_raw < TONE_W'(MIN_TONE)) ? TONE_W'(MIN_TONE) : g_tone_raw;
  assign g_reps     = (g_reps_raw == '0) ? REP_W'(1) : g_reps_raw;

  assign cur_dur  = (state_q == ON) ? on_q : off_q;
  assign pre_end  = (pre_q == PRE_W'(TICK_DIV-1));
  assign dur_end  = (dur_q == cur_dur - DUR_W'(1));
  assign last_rep = (rep_q == reps_q - REP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tone_q      <= '0;
      on_q        <= '0;
      off_q       <= '0;
      reps_q      <= '0;
      rep_q       <= '0;
      dur_q       <= '0;
      pre_q       <= '0;
      active_id_q <= '0;
      done_q      <= 1'b0;
      tone_rst_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      tone_rst_q <= 1'b0;
      if (hs) begin
        // a grant (from IDLE or by preemption) always starts a fresh pattern
        tone_q      <= g_tone;
        on_q        <= g_on;
        off_q       <= g_off;
        reps_q      <= g_reps;
        active_id_q <= gidx;
        rep_q       <= '0;
        dur_q       <= '0;
        pre_q       <= '0;
        if (g_on != '0) begin
          state_q    <= ON;
          tone_rst_q <= 1'b1;
        end else if (g_off != '0) begin
          state_q <= OFF;
        end else begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: ;
          ON: begin
            if (pre_end) begin
              pre_q <= '0;
              if (dur_end) begin
                dur_q <= '0;
                if (off_q != '0) begin
                  state_q <= OFF;
                end else if (last_rep) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  rep_q      <= rep_q + REP_W'(1);
                  tone_rst_q <= 1'b1;
                end
              end else begin
                dur_q <= dur_q + DUR_W'(1);
              end
            end else begin
              pre_q <= pre_q + PRE_W'(1);
            end
          end
          OFF: begin
            if (pre_end) begin
              pre_q <= '0;
              if (dur_end) begin
                dur_q <= '0;
                if (last_rep) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  rep_q <= rep_q + REP_W'(1);
                  if (on_q != '0) begin
                    state_q    <= ON;
                    tone_rst_q <= 1'b1;
                  end
                end
              end else begin
                dur_q <= dur_q + DUR_W'(1);
              end
            end else begin
              pre_q <= pre_q + PRE_W'(1);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  beep_tone_gen #(.TONE_W(TONE_W)) u_tone (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == ON),
    .restart_i (tone_rst_q),
    .half_i    (tone_q),
    .beep_o    (beep)
  );

  assign busy      = (state_q != IDLE);
  assign active_id = active_id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_beep_sched.sv
// Bench for beep_sched: per-cycle scoreboard built from an analytic pattern model,
// a table of single patterns, plus arbitration, reset-abort and preemption sequences.
module tb_beep_sched;
  localparam int NUM_REQ = 4;
  localparam int TONE_W  = 15;
  localparam int DUR_W   = 16;
  localparam int REP_W   = 4;
  localparam int TD      = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*TONE_W-1:0] req_tone;
  logic [NUM_REQ*DUR_W-1:0]  req_on, req_off;
  logic [NUM_REQ*REP_W-1:0]  req_reps;
  logic                      beep, busy, done;
  logic [ID_W-1:0]           active_id;

  always #5 clk = ~clk;

  beep_sched #(.NUM_REQ(NUM_REQ), .TONE_W(TONE_W), .DUR_W(DUR_W), .REP_W(REP_W),
               .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_tone(req_tone), .req_on(req_on), .req_off(req_off), .req_reps(req_reps),
    .beep(beep), .busy(busy), .active_id(active_id), .done(done));

  typedef struct {
    int        cyc;
    logic      busy;
    logic      beep;
    logic      done;
    logic [ID_W-1:0] id;
  } exp_t;

  typedef struct {
    int idx; int tone; int on; int off; int reps; int len;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) last_done = cyc;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("busy", busy, e.busy);
      chk("beep", beep, e.beep);
      chk("done", done, e.done);
      if (e.busy) chk("active_id", active_id, e.id);
    end
  end

  task automatic push(input int c, input logic b, input logic bp, input logic dn, input int id);
    exp_t r;
    r.cyc = c; r.busy = b; r.beep = bp; r.done = dn; r.id = ID_W'(id);
    sb.push_back(r);
  endtask

  // Expected per-cycle outputs from the handshake cycle t onward; beep lags the tone level by one.
  task automatic push_pattern(input int t, input int id, input int tone, input int on,
                              input int off, input int reps, output int done_cyc);
    int h, r, c;
    logic prev;
    h = (tone < 2) ? 2 : tone;
    r = (reps == 0) ? 1 : reps;
    c = t + 1;
    prev = 1'b0;
    for (int k = 0; k < r; k++) begin
      for (int j = 0; j < on*TD; j++) begin
        push(c, 1'b1, prev, 1'b0, id);
        prev = ((j % (2*h)) < h);
        c++;
      end
      for (int j = 0; j < off*TD; j++) begin
        push(c, 1'b1, prev, 1'b0, id);
        prev = 1'b0;
        c++;
      end
    end
    push(c, 1'b1, prev, 1'b1, id);
    done_cyc = c;
    push(c + 1, 1'b0, 1'b0, 1'b0, id);
  endtask

  task automatic set_req(input int i, input int tone, input int on, input int off, input int reps);
    req_tone[i*TONE_W +: TONE_W] = TONE_W'(tone);
    req_on[i*DUR_W +: DUR_W]     = DUR_W'(on);
    req_off[i*DUR_W +: DUR_W]    = DUR_W'(off);
    req_reps[i*REP_W +: REP_W]   = REP_W'(reps);
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int idx, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (req_ready[idx] === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", (t >= 0), 1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic run_single(input vec_t v);
    int t, d;
    set_req(v.idx, v.tone, v.on, v.off, v.reps);
    wait_grant(v.idx, 20, t);
    if (t < 0) return;
    push_pattern(t, v.idx, v.tone, v.on, v.off, v.reps, d);
    @(negedge clk);
    req_valid[v.idx] = 1'b0;
    drain(500);
    chk("done_latency", last_done - t, v.len);
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int t0, t1, t3, d0, d1;
    vecs[0] = '{2, 3, 2, 1, 2, 25};
    vecs[1] = '{1, 1, 3, 0, 0, 13};
    vecs[2] = '{0, 0, 0, 0, 3, 1};
    vecs[3] = '{3, 2, 0, 2, 2, 17};
    vecs[4] = '{1, 5, 1, 0, 3, 13};
    vecs[5] = '{2, 2, 1, 1, 1, 9};
    vecs[6] = '{0, 7, 2, 2, 1, 17};

    rst_n = 1'b0; req_valid = '0; req_tone = '0; req_on = '0; req_off = '0; req_reps = '0;
    repeat (3) @(negedge clk);
    chk("rst_beep", beep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_ready", req_ready, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    // two simultaneous requesters: lowest index wins, the other waits for IDLE after done
    set_req(0, 2, 1, 1, 1);
    set_req(3, 4, 1, 0, 2);
    #1 chk("arb_ready", req_ready, 4'b0001);
    wait_grant(0, 5, t0);
    push_pattern(t0, 0, 2, 1, 1, 1, d0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_grant(3, 60, t3);
    chk("arb_next_grant", t3, d0 + 1);
    push_pattern(t3, 3, 4, 1, 0, 2, d1);
    @(negedge clk);
    req_valid[3] = 1'b0;
    drain(200);
    chk("arb_done_cycle", last_done, d1);
    repeat (2) @(negedge clk);

    // reset in the middle of ON aborts at once with no done pulse
    set_req(2, 3, 5, 1, 1);
    wait_grant(2, 5, t0);
    push_pattern(t0, 2, 3, 5, 1, 1, d0);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_beep", beep, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_active_id", active_id, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // higher-priority request arriving while a lower one plays
    set_req(1, 2, 2, 1, 1);
    wait_grant(1, 5, t1);
    push_pattern(t1, 1, 2, 2, 1, 1, d1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    set_req(0, 3, 1, 0, 1);
`ifdef BEEP_SCHED_PREEMPT_EN
    #1 chk("preempt_ready", req_ready, 4'b0001);
    wait_grant(0, 5, t0);
    chk("preempt_grant_cycle", t0, t1 + 3);
    sb.delete();
`else
    #1 chk("hold_ready", req_ready, 4'b0000);
    wait_grant(0, 60, t0);
    chk("wait_grant_cycle", t0, d1 + 1);
`endif
    push_pattern(t0, 0, 3, 1, 0, 1, d0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drain(200);
    chk("preempt_done_cycle", last_done, d0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
